// File: rtl/cmn_alloc_pkg.sv
// rtl/cmn_alloc_pkg.sv - shared constants and op encoding for slot allocators
package cmn_alloc_pkg;

    localparam int CMN_ALLOC_MIN_ENTRY = 2;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_REL   = 2'b01,
        OP_ALLOC = 2'b10,
        OP_BOTH  = 2'b11
    } alloc_op_e;

endpackage

// File: rtl/cmn_lead_one_rev.sv
// rtl/cmn_lead_one_rev.sv - highest-index set-bit picker (one-hot, binary, any)
module cmn_lead_one_rev #(
    parameter  int N  = 16,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [N-1:0]  oh,
    output logic [AW-1:0] bin,
    output logic          any
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        oh  = '0;
        bin = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
                bin   = AW'(i);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmn_entry_alloc.sv
// rtl/cmn_entry_alloc.sv - free-bitmap slot allocator; CMN_ENTRY_ALLOC_CHK_EN enables release checking
module cmn_entry_alloc
    import cmn_alloc_pkg::*;
#(
    parameter  int ENTRY_NUM = 16,
    localparam int AWIDTH    = $clog2(ENTRY_NUM),
    localparam int CWIDTH    = $clog2(ENTRY_NUM + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req,
    output logic                 alloc_gnt,
    output logic [ENTRY_NUM-1:0] alloc_idx_oh,
    output logic [AWIDTH-1:0]    alloc_idx_bin,
    input  logic                 rel_vld,
    input  logic [AWIDTH-1:0]    rel_idx_bin,
    input  logic                 flush,
    output logic [CWIDTH-1:0]    free_cnt,
    output logic                 all_free,
    output logic                 none_free,
    output logic                 err_dbl_rel
);

    logic [ENTRY_NUM-1:0] free_vec_q, free_vec_d;
    logic [CWIDTH-1:0]    free_cnt_q, free_cnt_d;
    logic                 all_free_q, all_free_d;
    logic                 none_free_q, none_free_d;
    logic                 err_q, err_d;
    logic                 any_free;
    logic [ENTRY_NUM-1:0] rel_oh;
    logic                 legal_rel;
    alloc_op_e            op;

    cmn_lead_one_rev #(.N(ENTRY_NUM)) u_pick (
        .vec (free_vec_q),
        .oh  (alloc_idx_oh),
        .bin (alloc_idx_bin),
        .any (any_free)
    );

    // rst_n gates the grant so an async reset drops it without waiting for an edge.
    assign alloc_gnt = alloc_req & any_free & ~flush & rst_n;

    // Out-of-range indices decode to zero, which makes them no-ops naturally.
    always_comb begin
        rel_oh = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (rel_idx_bin == AWIDTH'(i)) rel_oh[i] = 1'b1;
        end
    end

    assign legal_rel = rel_vld & ~flush & (|(rel_oh & ~free_vec_q));
    assign op        = alloc_op_e'({alloc_gnt, legal_rel});

    always_comb begin
        free_vec_d = free_vec_q;
        free_cnt_d = free_cnt_q;
        if (flush) begin
            free_vec_d = '1;
            free_cnt_d = CWIDTH'(ENTRY_NUM);
        end else begin
            if (alloc_gnt) free_vec_d = free_vec_d & ~alloc_idx_oh;
            if (legal_rel) free_vec_d = free_vec_d | rel_oh;
            case (op)
                OP_ALLOC: free_cnt_d = free_cnt_q - CWIDTH'(1);
                OP_REL:   free_cnt_d = free_cnt_q + CWIDTH'(1);
                default:  free_cnt_d = free_cnt_q;
            endcase
        end
        all_free_d  = (free_cnt_d == CWIDTH'(ENTRY_NUM));
        none_free_d = (free_cnt_d == '0);
    end

`ifdef CMN_ENTRY_ALLOC_CHK_EN
    logic rel_in_range;
    logic bad_rel;

    assign rel_in_range = |rel_oh;
    assign bad_rel      = rel_vld & ~flush & (~rel_in_range | (|(rel_oh & free_vec_q)));
    assign err_d        = err_q | bad_rel;

    chk_bad_rel: assert property (@(posedge clk) disable iff (!rst_n) !bad_rel)
        else $error("cmn_entry_alloc: release of free or out-of-range slot %0d", rel_idx_bin);
`else
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_vec_q  <= '1;
            free_cnt_q  <= CWIDTH'(ENTRY_NUM);
            all_free_q  <= 1'b1;
            none_free_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            free_vec_q  <= free_vec_d;
            free_cnt_q  <= free_cnt_d;
            all_free_q  <= all_free_d;
            none_free_q <= none_free_d;
            err_q       <= err_d;
        end
    end

    assign free_cnt    = free_cnt_q;
    assign all_free    = all_free_q;
    assign none_free   = none_free_q;
    assign err_dbl_rel = err_q;

endmodule

// File: tb/tb_cmn_entry_alloc.sv
// tb/tb_cmn_entry_alloc.sv - randomized bench for cmn_entry_alloc against a slot-set model
module tb_cmn_entry_alloc;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alloc_req;
    logic         alloc_gnt;
    logic [N-1:0] alloc_idx_oh;
    logic [3:0]   alloc_idx_bin;
    logic         rel_vld;
    logic [3:0]   rel_idx_bin;
    logic         flush;
    logic [4:0]   free_cnt;
    logic         all_free;
    logic         none_free;
    logic         err_dbl_rel;

    int n_chk  = 0;
    int n_fail = 0;

    bit m_free [N];
    bit m_err;

    always #5 clk = ~clk;

    cmn_entry_alloc #(.ENTRY_NUM(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_req     (alloc_req),
        .alloc_gnt     (alloc_gnt),
        .alloc_idx_oh  (alloc_idx_oh),
        .alloc_idx_bin (alloc_idx_bin),
        .rel_vld       (rel_vld),
        .rel_idx_bin   (rel_idx_bin),
        .flush         (flush),
        .free_cnt      (free_cnt),
        .all_free      (all_free),
        .none_free     (none_free),
        .err_dbl_rel   (err_dbl_rel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_free[i];
        return c;
    endfunction

    function automatic int m_pick();
        int p = -1;
        for (int i = 0; i < N; i++) if (m_free[i]) p = i;
        return p;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_free[i] = 1'b1;
        m_err = 1'b0;
    endtask

    // Called just after a negedge: drive, check against the model, advance one cycle.
    task automatic step(input logic req, input logic rv, input logic [3:0] ri, input logic fl);
        int  p;
        int  c;
        bit  eg;
        alloc_req   = req;
        rel_vld     = rv;
        rel_idx_bin = ri;
        flush       = fl;
        #1;
        p  = m_pick();
        c  = m_count();
        eg = req && (p >= 0) && !fl;
        check("alloc_gnt", alloc_gnt, eg);
        if (eg) begin
            check("alloc_idx_bin", alloc_idx_bin, p);
            check("alloc_idx_oh", alloc_idx_oh, 32'd1 << p);
        end
        check("free_cnt", free_cnt, c);
        check("all_free", all_free, c == N);
        check("none_free", none_free, c == 0);
        check("err_dbl_rel", err_dbl_rel, m_err);
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < N; i++) m_free[i] = 1'b1;
        end else begin
`ifdef CMN_ENTRY_ALLOC_CHK_EN
            if (rv && m_free[ri]) m_err = 1'b1;
`endif
            if (rv && !m_free[ri]) m_free[ri] = 1'b1;
            if (eg) m_free[p] = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int ri;
        rst_n       = 1'b0;
        alloc_req   = 1'b0;
        rel_vld     = 1'b0;
        rel_idx_bin = '0;
        flush       = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        check("reset free_cnt", free_cnt, 16);
        check("reset all_free", all_free, 1);
        check("reset none_free", none_free, 0);
        check("reset err", err_dbl_rel, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First grant is slot 15, then drain to empty and try once more.
        step(1, 0, 0, 0);
        check("first cnt", free_cnt, 15);
        check("first all_free", all_free, 0);
        for (int k = 0; k < 15; k++) step(1, 0, 0, 0);
        check("full none_free", none_free, 1);
        step(1, 0, 0, 0);

        // Release slot 7 on a full pool, then reallocate it.
        step(0, 1, 4'd7, 0);
        check("rel7 cnt", free_cnt, 1);
        #1 alloc_req = 1'b1;
        #1 check("realloc bin", alloc_idx_bin, 7);
        step(1, 0, 0, 0);

        // Build free set {11,10,2,1,0} with slot 3 allocated.
        step(0, 0, 0, 1);
        for (int k = 0; k < 13; k++) step(1, 0, 0, 0);
        step(0, 1, 4'd10, 0);
        step(0, 1, 4'd11, 0);
        check("pre-both cnt", free_cnt, 5);
        step(1, 1, 4'd3, 0);
        check("both cnt", free_cnt, 5);
        #1 alloc_req = 1'b1;
        #1 check("both next pick", alloc_idx_bin, 10);
        step(0, 0, 0, 0);

        // Flush beats a same-cycle alloc and release.
        step(1, 1, 4'd5, 1);
        check("flush cnt", free_cnt, 16);
        check("flush all_free", all_free, 1);

        // Re-release of a free slot: no-op (and sticky error when checking is built in).
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
        step(0, 1, 4'd2, 0);
        check("dbl cnt", free_cnt, 12);
`ifdef CMN_ENTRY_ALLOC_CHK_EN
        check("dbl err", err_dbl_rel, 1);
        step(0, 0, 0, 0);
        check("dbl err sticky", err_dbl_rel, 1);
`endif

        for (int k = 0; k < 400; k++) begin
            ri = $urandom_range(N - 1);
`ifdef CMN_ENTRY_ALLOC_CHK_EN
            if (m_free[ri]) begin
                ri = -1;
                for (int i = 0; i < N; i++) if (!m_free[i]) ri = i;
            end
            if (ri < 0)
                step($urandom_range(3) != 0, 0, 0, $urandom_range(40) == 0);
            else
`endif
            step($urandom_range(3) != 0, $urandom_range(1), 4'(ri), $urandom_range(40) == 0);
        end

        // Asynchronous reset between edges clears everything at once.
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
        alloc_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("arst gnt", alloc_gnt, 0);
        check("arst cnt", free_cnt, 16);
        check("arst all_free", all_free, 1);
        check("arst none_free", none_free, 0);
        check("arst err", err_dbl_rel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
